up_bus_master: RTL
==================

// Module: up_bus_master
// PURPOSE
// - Command-driven master for the up_* register bus (up_csn/up_wbe/up_addr/up_data_io).
// - Sits directly upstream of the register slave: converts a valid/ready command stream into bus cycles.
// - Returns read data on a response strobe.
// - Used by the bench and the JTAG side to load and read back slave registers.
// PARAMETERS
// - ADDR_W   16  up_addr / cmd_addr width
// - DATA_W   32  data width
// - RD_WAIT  2   cycles from read-cycle start to rdata capture; min 2, matching the slave's registered read
// PORTS
// - up_clk      in     1       bus clock, all logic on posedge
// - up_rstn     in     1       synchronous active-low reset
// - cmd_valid   in     1       command present
// - cmd_ready   out    1       master accepts command this cycle
// - cmd_wr      in     1       1 = write, 0 = read
// - cmd_addr    in     ADDR_W  byte address, passed unchanged to up_addr
// - cmd_wdata   in     DATA_W  write data
// - rsp_valid   out    1       one-cycle strobe, read data valid
// - rsp_rdata   out    DATA_W  captured read data, held until next read
// - busy        out    1       FSM not in IDLE
// - up_csn      out    1       chip select, active low
// - up_wbe      out    1       write enable, active low; high = read
// - up_addr     out    ADDR_W  bus address
// - up_data_io  inout  DATA_W  driven only while (!up_csn && !up_wbe), else 'z
// - stat_wr     out    16      completed-write count (see CONFIGURATION)
// - stat_rd     out    16      completed-read count (see CONFIGURATION)
// BEHAVIOUR
// - Reset (up_rstn = 0 at posedge):
//   - up_csn = 1, up_wbe = 1, up_addr = 0, data bus released.
//   - cmd_ready = 0, rsp_valid = 0, rsp_rdata = 0, busy = 0, stat_* = 0.
//   - FSM -> IDLE. Reset mid-cycle aborts the bus cycle immediately; no response issued.
// - All bus outputs are registered. No combinational path from cmd_* to up_*.
// - FSM states:
//   - IDLE:
//     - cmd_ready = 1.
//     - On cmd_valid, latch cmd_* and set up_addr and up_csn = 0.
//     - Write: up_wbe = 0, drive cmd_wdata -> WR.
//     - Read: up_wbe = 1, count = 0 -> RD.
//   - WR:
//     - Exactly one cycle with csn/wbe low; the slave samples at this posedge.
//     - Next: up_csn = 1, up_wbe = 1, bus released, stat_wr++ -> IDLE.
//     - Back-to-back write throughput: 1 write per 2 cycles.
//   - RD:
//     - csn low, wbe high; count++ each cycle.
//     - When count == RD_WAIT-1: rsp_rdata <= up_data_io, rsp_valid = 1 for 1 cycle, up_csn = 1, stat_rd++ -> TURN.
//   - TURN:
//     - One idle cycle (csn = 1, wbe = 1, bus 'z) so the slave releases the bus before any following write.
//     - -> IDLE.
// - cmd_ready is 0 in every state except IDLE. A command is accepted only when cmd_valid && cmd_ready.
// - Read latency: cmd accept edge to rsp_valid = RD_WAIT cycles. Read throughput: 1 per RD_WAIT+2 cycles.
// - up_addr holds its last value between cycles; it is only meaningful while up_csn = 0.
// - stat_wr / stat_rd wrap 0xFFFF -> 0x0000 with no saturation.
// - cmd_* changing while busy is ignored; the latched values are used.
// CONFIGURATION
// - Macro UP_BUS_MASTER_STATS_EN.
// - Defined: stat_wr / stat_rd counters are implemented as described above.
// - Undefined: stat_wr / stat_rd are tied to 16'h0000 and no counter flops are built. All other behaviour is identical.
// TESTING
// - Write then read: write 0x0004 <- 0xDEADBEEF, then read 0x0004 -> rsp_valid 2 cycles after accept, rsp_rdata = 0xDEADBEEF.
// - Back-to-back: 4 writes (addr 0x0,0x4,0x8,0xC; data 0x11..0x44) with cmd_valid held high -> cmd_ready pulses every 2nd cycle; readback returns 0x11,0x22,0x33,0x44.
// - Turnaround: read 0x8 immediately followed by write 0x8 <- 0x5A -> up_data_io never driven by both sides (no X on bus); final read = 0x5A.
// - Bus idle: while idle or in TURN -> up_data_io = 'z, up_csn = 1; cmd_ready = 0 throughout WR / RD / TURN.
// - Reset mid-read: assert up_rstn = 0 in RD -> next edge up_csn = 1, rsp_valid never pulses, busy = 0, cmd_ready = 0 until reset is released.
// - Stats (macro on): 3 writes + 2 reads -> stat_wr = 3, stat_rd = 2. Preload 0xFFFF + 1 write -> stat_wr = 0. Macro off -> both stay 0.

Source files
------------

// File: rtl/up_bus_master_if.sv
// Command/response handshake bundle between a command source and up_bus_master.
// Latency: none, wires only.
// Backpressure: cmd_valid/cmd_ready handshake; rsp_valid is a one-cycle strobe with no ready.
interface up_bus_master_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;

   // Side seen by up_bus_master
   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata
   );

   // Side seen by whoever issues commands
   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/up_bus_master.sv
// Converts a valid/ready command stream into up_* register bus cycles; returns read data on a strobe.
// Latency: write = 2 cycles per command; read rsp_valid RD_WAIT cycles after accept, RD_WAIT+2 per read.
// Backpressure: cmd_ready only in IDLE; rsp_valid has no ready. Optional macro UP_BUS_MASTER_STATS_EN adds stat counters.
module up_bus_master #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 32,
   parameter int RD_WAIT = 2     // >= 2: the slave registers its read data
) (
   input  logic              up_clk,
   input  logic              up_rstn,
   up_bus_master_if.master   cmd_if,
   output logic              busy,
   output logic              up_csn,
   output logic              up_wbe,
   output logic [ADDR_W-1:0] up_addr,
   inout  wire  [DATA_W-1:0] up_data_io,
   output logic [15:0]       stat_wr,
   output logic [15:0]       stat_rd
);

   localparam int CNT_W = $clog2(RD_WAIT);

   typedef enum logic [1:0] {IDLE, WR, RD, TURN} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              rdy_q;
   logic              accept;
   logic              rd_last;
   logic              csn_nxt, wbe_nxt;
   logic              ld_cmd, cap_rd, wr_done, rd_done;
   logic [DATA_W-1:0] wdata_q;
   logic              rsp_vld_q;
   logic [DATA_W-1:0] rsp_dat_q;

   assign accept  = cmd_if.cmd_valid && rdy_q;
   assign rd_last = (cnt == CNT_W'(RD_WAIT - 1));

   // Next-state and bus-control decode; all bus outputs are registered from these
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      csn_nxt   = up_csn;
      wbe_nxt   = up_wbe;
      ld_cmd    = 1'b0;
      cap_rd    = 1'b0;
      wr_done   = 1'b0;
      rd_done   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               ld_cmd  = 1'b1;
               csn_nxt = 1'b0;
               cnt_nxt = '0;
               if (cmd_if.cmd_wr) begin
                  wbe_nxt   = 1'b0;
                  state_nxt = WR;
               end else begin
                  wbe_nxt   = 1'b1;
                  state_nxt = RD;
               end
            end
         end
         WR: begin
            // slave samples the write at this edge; release the bus
            csn_nxt   = 1'b1;
            wbe_nxt   = 1'b1;
            wr_done   = 1'b1;
            state_nxt = IDLE;
         end
         RD: begin
            if (rd_last) begin
               cap_rd    = 1'b1;
               csn_nxt   = 1'b1;
               rd_done   = 1'b1;
               state_nxt = TURN;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         TURN: begin
            // one dead cycle so the slave lets go of up_data_io before a write
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FSM state, read wait counter and registered command-ready
   always_ff @(posedge up_clk) begin
      if (!up_rstn) begin
         state <= IDLE;
         cnt   <= '0;
         rdy_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         rdy_q <= (state_nxt == IDLE);
      end
   end

   // Bus control, address and write-data registers; address holds between cycles
   always_ff @(posedge up_clk) begin
      if (!up_rstn) begin
         up_csn  <= 1'b1;
         up_wbe  <= 1'b1;
         up_addr <= '0;
         wdata_q <= '0;
      end else begin
         up_csn <= csn_nxt;
         up_wbe <= wbe_nxt;
         if (ld_cmd) begin
            up_addr <= cmd_if.cmd_addr;
            wdata_q <= cmd_if.cmd_wdata;
         end
      end
   end

   assign up_data_io = (!up_csn && !up_wbe) ? wdata_q : {DATA_W{1'bz}};

   // Read response: capture bus data and pulse the strobe for one cycle
   always_ff @(posedge up_clk) begin
      if (!up_rstn) begin
         rsp_vld_q <= 1'b0;
         rsp_dat_q <= '0;
      end else begin
         rsp_vld_q <= cap_rd;
         if (cap_rd) begin
            rsp_dat_q <= up_data_io;
         end
      end
   end

   assign cmd_if.cmd_ready = rdy_q;
   assign cmd_if.rsp_valid = rsp_vld_q;
   assign cmd_if.rsp_rdata = rsp_dat_q;
   assign busy             = (state != IDLE);

`ifdef UP_BUS_MASTER_STATS_EN
   logic [15:0] stat_wr_q, stat_rd_q;

   // Completed-cycle counters, free-running wrap at 16 bits
   always_ff @(posedge up_clk) begin
      if (!up_rstn) begin
         stat_wr_q <= '0;
         stat_rd_q <= '0;
      end else begin
         if (wr_done) stat_wr_q <= stat_wr_q + 16'd1;
         if (rd_done) stat_rd_q <= stat_rd_q + 16'd1;
      end
   end

   assign stat_wr = stat_wr_q;
   assign stat_rd = stat_rd_q;
`else
   logic unused_done;
   assign unused_done = wr_done ^ rd_done;
   assign stat_wr     = 16'h0000;
   assign stat_rd     = 16'h0000;
`endif

endmodule
